// File: rtl/wb_pipeline_slice_if.sv
// wb_pipeline_slice_if: Wishbone B4 pipelined bus bundle with master/slave views
interface wb_pipeline_slice_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [AW-1:0]     adr;
    logic [DW/8-1:0]   sel;
    logic [DW-1:0]     dat_w;
    logic [DW-1:0]     dat_r;
    logic              stall;
    logic              ack;
    logic              err;
    modport master (output cyc, stb, we, adr, sel, dat_w, input stall, ack, err, dat_r);
    modport slave  (input cyc, stb, we, adr, sel, dat_w, output stall, ack, err, dat_r);
endinterface

// File: rtl/wb_pipeline_slice.sv
// wb_pipeline_slice: registered Wishbone B4 pipelined slice (2-entry skid request path, registered response path)
module wb_pipeline_slice #(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_pipeline_slice_if.slave    s,
    wb_pipeline_slice_if.master   m
);
    localparam int SELW = DW / 8;
    localparam int CW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW   = 1 + AW + SELW + DW;

    logic [PW-1:0] in_pl, or_pl_q, or_pl_d, sk_pl_q, sk_pl_d;
    logic          or_v_q, or_v_d, sk_v_q, sk_v_d;
    logic          stall_q, stall_d, cyc_q;
    logic          ack_q, ack_d, err_q, err_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          abort, up_acc, or_free, dec;

    assign in_pl   = {s.we, s.adr, s.sel, s.dat_w};
    assign abort   = !s.cyc;
    assign up_acc  = s.cyc & s.stb & !stall_q;
    assign or_free = !or_v_q | !m.stall;
    assign dec     = (ack_q | err_q) & (cnt_q != '0);

    // Next state: skid refills the output register first, stall looks one cycle ahead, abort clears everything
    always_comb begin
        or_v_d  = !abort & (or_free ? (sk_v_q | up_acc) : 1'b1);
        sk_v_d  = !abort & !or_free & (sk_v_q | up_acc);
        or_pl_d = or_free ? (sk_v_q ? sk_pl_q : in_pl) : or_pl_q;
        sk_pl_d = (!or_free && up_acc) ? in_pl : sk_pl_q;
        cnt_d   = abort ? '0 : cnt_q + CW'(up_acc) - CW'(dec);
        stall_d = sk_v_d | (cnt_d == CW'(MAX_OUTSTANDING));
        err_d   = m.err & cyc_q & s.cyc;
        ack_d   = m.ack & cyc_q & s.cyc & !m.err;
        dat_d   = m.ack ? m.dat_r : dat_q;
    end

    // State registers; upstream is stalled while in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            or_v_q  <= 1'b0;
            sk_v_q  <= 1'b0;
            or_pl_q <= '0;
            sk_pl_q <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b1;
            cyc_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            or_v_q  <= or_v_d;
            sk_v_q  <= sk_v_d;
            or_pl_q <= or_pl_d;
            sk_pl_q <= sk_pl_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            cyc_q   <= s.cyc;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    assign s.stall = stall_q;
    assign s.ack   = ack_q;
    assign s.err   = err_q;
    assign s.dat_r = dat_q;
    assign m.cyc   = cyc_q;
    assign m.stb   = or_v_q;
    assign {m.we, m.adr, m.sel, m.dat_w} = or_pl_q;
endmodule

// File: tb/tb_wb_pipeline_slice.sv
// tb_wb_pipeline_slice: directed self-checking bench for wb_pipeline_slice
module tb_wb_pipeline_slice;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    wb_pipeline_slice_if #(.AW(32), .DW(32)) u ();
    wb_pipeline_slice_if #(.AW(32), .DW(32)) d ();

    wb_pipeline_slice #(.AW(32), .DW(32), .MAX_OUTSTANDING(4)) dut (
        .clk (clk),
        .rst (rst),
        .s   (u),
        .m   (d)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic stb, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        u.stb   = stb;
        u.we    = we;
        u.adr   = adr;
        u.dat_w = dat;
    endtask

    task automatic ack_n(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            d.ack = 1'b1;
            tick();
            chk(tag, u.ack, 1);
        end
        d.ack = 1'b0;
        tick();
        chk(tag, u.ack, 0);
    endtask

    initial begin
        u.cyc = 0; u.stb = 0; u.we = 0; u.adr = 0; u.sel = 4'hF; u.dat_w = 0;
        d.stall = 0; d.ack = 0; d.err = 0; d.dat_r = 0;
        rst = 1;
        tick();
        tick();
        chk("rst_stall", u.stall, 1);
        chk("rst_mcyc", d.cyc, 0);
        chk("rst_mstb", d.stb, 0);
        chk("rst_sack", u.ack, 0);
        chk("rst_serr", u.err, 0);
        chk("rst_sdat", u.dat_r, 0);
        rst = 0;
        tick();
        chk("post_rst_stall", u.stall, 0);

        // single read
        u.cyc = 1;
        req(1, 0, 32'h1000, 0);
        tick();
        chk("t1_mstb", d.stb, 1);
        chk("t1_madr", d.adr, 32'h1000);
        chk("t1_mwe", d.we, 0);
        chk("t1_mcyc", d.cyc, 1);
        req(0, 0, 0, 0);
        tick();
        chk("t1_mstb_drop", d.stb, 0);
        d.ack = 1; d.dat_r = 32'hDEADBEEF;
        tick();
        chk("t1_sack", u.ack, 1);
        chk("t1_sdat", u.dat_r, 32'hDEADBEEF);
        chk("t1_serr", u.err, 0);
        d.ack = 0; d.dat_r = 0;
        tick();
        chk("t1_sack_low", u.ack, 0);
        chk("t1_sdat_hold", u.dat_r, 32'hDEADBEEF);

        // four back-to-back writes with pipelined acks
        for (int i = 0; i < 7; i++) begin
            req(i < 4, 1, 32'h2000 + 32'(4 * i), 32'hA0 + 32'(i));
            d.ack = (i >= 2 && i <= 5);
            tick();
            if (i < 4) begin
                chk("t2_mstb", d.stb, 1);
                chk("t2_madr", d.adr, 32'h2000 + 32'(4 * i));
                chk("t2_mdat", d.dat_w, 32'hA0 + 32'(i));
                chk("t2_mwe", d.we, 1);
            end
            chk("t2_sstall", u.stall, 0);
            chk("t2_sack", u.ack, (i >= 2 && i <= 5));
        end
        chk("t2_mstb_end", d.stb, 0);
        d.ack = 0;

        // downstream stall fills the skid register
        req(1, 0, 32'h3000, 0);
        tick();
        chk("t3_a0", d.adr, 32'h3000);
        req(1, 0, 32'h3004, 0);
        d.stall = 1;
        tick();
        chk("t3_hold0", d.adr, 32'h3000);
        chk("t3_stall0", u.stall, 1);
        req(1, 0, 32'h3008, 0);
        tick();
        chk("t3_hold1", d.adr, 32'h3000);
        chk("t3_stall1", u.stall, 1);
        tick();
        chk("t3_hold2", d.adr, 32'h3000);
        chk("t3_stall2", u.stall, 1);
        d.stall = 0;
        tick();
        chk("t3_a1", d.adr, 32'h3004);
        chk("t3_a1_stb", d.stb, 1);
        chk("t3_unstall", u.stall, 0);
        tick();
        chk("t3_a2", d.adr, 32'h3008);
        chk("t3_a2_stb", d.stb, 1);
        req(0, 0, 0, 0);
        tick();
        chk("t3_idle", d.stb, 0);
        ack_n(3, "t3_ack");

        // outstanding limit
        for (int i = 0; i < 4; i++) begin
            req(1, 0, 32'h4000 + 32'(4 * i), 0);
            tick();
            chk("t4_madr", d.adr, 32'h4000 + 32'(4 * i));
            chk("t4_stall", u.stall, (i == 3));
        end
        req(1, 0, 32'h4010, 0);
        tick();
        chk("t4_5th_stalled", u.stall, 1);
        chk("t4_5th_not_issued", d.stb, 0);
        d.ack = 1;
        tick();
        chk("t4_ack_stall", u.stall, 1);
        chk("t4_ack", u.ack, 1);
        d.ack = 0;
        tick();
        chk("t4_released", u.stall, 0);
        chk("t4_still_idle", d.stb, 0);
        tick();
        chk("t4_5th_stb", d.stb, 1);
        chk("t4_5th_adr", d.adr, 32'h4010);
        chk("t4_full_again", u.stall, 1);
        req(0, 0, 0, 0);
        ack_n(4, "t4_drain");
        chk("t4_empty", u.stall, 0);

        // error on the middle of three reads
        for (int i = 0; i < 6; i++) begin
            req(i < 3, 0, 32'h5000 + 32'(4 * i), 0);
            d.ack   = (i == 2 || i == 4);
            d.err   = (i == 3);
            d.dat_r = (i == 2) ? 32'h11111111 : (i == 4) ? 32'h33333333 : 32'h0;
            tick();
            chk("t5_sack", u.ack, (i == 2 || i == 4));
            chk("t5_serr", u.err, (i == 3));
            if (i == 2) chk("t5_dat0", u.dat_r, 32'h11111111);
            if (i == 4) chk("t5_dat2", u.dat_r, 32'h33333333);
        end
        d.ack = 0; d.err = 0;
        tick();

        // abort with two outstanding, late ack discarded
        req(1, 0, 32'h6000, 0);
        tick();
        req(1, 0, 32'h6004, 0);
        tick();
        req(0, 0, 0, 0);
        tick();
        u.cyc = 0;
        d.ack = 1;
        tick();
        chk("t6_mcyc", d.cyc, 0);
        chk("t6_mstb", d.stb, 0);
        chk("t6_sack0", u.ack, 0);
        tick();
        chk("t6_sack1", u.ack, 0);
        d.ack = 0;
        u.cyc = 1;
        for (int i = 0; i < 4; i++) begin
            req(1, 0, 32'h7000 + 32'(4 * i), 0);
            tick();
            chk("t6_mcyc_new", d.cyc, 1);
            chk("t6_stall_new", u.stall, (i == 3));
        end
        u.cyc = 0;
        req(0, 0, 0, 0);
        tick();
        chk("t6_abort_cyc", d.cyc, 0);
        chk("t6_abort_stall", u.stall, 0);

        // reset mid-burst
        u.cyc = 1;
        req(1, 0, 32'h8000, 0);
        tick();
        rst = 1;
        tick();
        chk("rst2_stall", u.stall, 1);
        chk("rst2_mstb", d.stb, 0);
        chk("rst2_mcyc", d.cyc, 0);
        chk("rst2_sdat", u.dat_r, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
